// File: rtl/openmips_run_ctrl.sv
// Run controller for the OpenMIPS minimal SOPC: CPU reset hold, run-cycle
// budget and program-completion detection with registered status outputs.
module openmips_run_ctrl #(
  parameter int HOLD_CYCLES = 10,
  parameter int RUN_CYCLES  = 100,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             halt_i,
  output logic             cpu_rst_o,
  output logic             cpu_stall_o,
  output logic             running_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycles_o
);

  // state  | meaning
  // S_HOLD | CPU held in reset for the hold period
  // S_RUN  | CPU executing, run cycles counted against the budget
  // S_DONE | CPU stalled, status frozen until start_i
  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;

  localparam int               HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic             BUDGET_EN = (RUN_CYCLES != 0);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [CNT_W-1:0] w_cycles_nxt;
  logic             w_timeout_nxt;

  always_comb begin
    w_next        = r_state;
    w_hold_nxt    = r_hold_cnt;
    w_cycles_nxt  = cycles_o;
    w_timeout_nxt = timeout_o;
    case (r_state)
      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_next     = S_RUN;
          w_hold_nxt = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + ONE;
        end
      end
      S_RUN: begin
        // Saturate so an unbudgeted run never wraps the count.
        if (cycles_o != '1) w_cycles_nxt = cycles_o + ONE;
        if (halt_i) begin
          w_next        = S_DONE;
          w_timeout_nxt = 1'b0;
        end else if (BUDGET_EN && (cycles_o == RUN_LAST)) begin
          w_next        = S_DONE;
          w_timeout_nxt = 1'b1;
        end
      end
      S_DONE: begin
        if (start_i) begin
          w_next        = S_HOLD;
          w_hold_nxt    = '0;
          w_cycles_nxt  = '0;
          w_timeout_nxt = 1'b0;
        end
      end
      default: begin
        w_next     = S_HOLD;
        w_hold_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HOLD;
      r_hold_cnt  <= '0;
      cycles_o    <= '0;
      cpu_rst_o   <= 1'b1;
      cpu_stall_o <= 1'b0;
      running_o   <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_hold_cnt  <= w_hold_nxt;
      cycles_o    <= w_cycles_nxt;
      cpu_rst_o   <= (w_next == S_HOLD);
      cpu_stall_o <= (w_next == S_DONE);
      running_o   <= (w_next == S_RUN);
      done_o      <= (w_next == S_DONE);
      timeout_o   <= w_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_openmips_run_ctrl.sv
// Bench for openmips_run_ctrl: directed scenarios plus random stimulus on a
// default instance and a small (HOLD=0, RUN=0, CNT_W=4) instance.
module tb_openmips_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst = 1'b1, a_start = 1'b0, a_halt = 1'b0;
  logic a_cpu_rst, a_stall, a_running, a_done, a_timeout;
  logic [15:0] a_cycles;
  logic b_rst = 1'b1, b_start = 1'b0, b_halt = 1'b0;
  logic b_cpu_rst, b_stall, b_running, b_done, b_timeout;
  logic [3:0] b_cycles;

  openmips_run_ctrl dut_a (
    .clk(clk), .rst(a_rst), .start_i(a_start), .halt_i(a_halt),
    .cpu_rst_o(a_cpu_rst), .cpu_stall_o(a_stall), .running_o(a_running),
    .done_o(a_done), .timeout_o(a_timeout), .cycles_o(a_cycles)
  );

  openmips_run_ctrl #(.HOLD_CYCLES(0), .RUN_CYCLES(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(b_rst), .start_i(b_start), .halt_i(b_halt),
    .cpu_rst_o(b_cpu_rst), .cpu_stall_o(b_stall), .running_o(b_running),
    .done_o(b_done), .timeout_o(b_timeout), .cycles_o(b_cycles)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase 0=reset hold, 1=running, 2=finished.
  int HE[2]   = '{10, 1};
  int RB[2]   = '{100, 0};
  int MAXC[2] = '{65535, 15};
  int m_ph[2]  = '{0, 0};
  int m_hl[2]  = '{0, 0};
  int m_cyc[2] = '{0, 0};
  bit m_to[2]  = '{1'b0, 1'b0};

  task automatic model_edge(input int k, input bit r, input bit s, input bit h);
    if (r) begin
      m_ph[k] = 0; m_hl[k] = HE[k]; m_cyc[k] = 0; m_to[k] = 1'b0;
    end else if (m_ph[k] == 0) begin
      m_hl[k] = m_hl[k] - 1;
      if (m_hl[k] == 0) m_ph[k] = 1;
    end else if (m_ph[k] == 1) begin
      if (m_cyc[k] < MAXC[k]) m_cyc[k] = m_cyc[k] + 1;
      if (h) begin
        m_ph[k] = 2; m_to[k] = 1'b0;
      end else if (RB[k] != 0 && m_cyc[k] == RB[k]) begin
        m_ph[k] = 2; m_to[k] = 1'b1;
      end
    end else if (s) begin
      m_ph[k] = 0; m_hl[k] = HE[k]; m_cyc[k] = 0; m_to[k] = 1'b0;
    end
  endtask

  function automatic logic [20:0] exp_vec(input int k);
    return {m_ph[k] == 0, m_ph[k] == 2, m_ph[k] == 1, m_ph[k] == 2, m_to[k], 16'(m_cyc[k])};
  endfunction

  function automatic logic [20:0] obs_a();
    return {a_cpu_rst, a_stall, a_running, a_done, a_timeout, a_cycles};
  endfunction

  function automatic logic [20:0] obs_b();
    return {b_cpu_rst, b_stall, b_running, b_done, b_timeout, 12'h000, b_cycles};
  endfunction

  task automatic tick;
    @(posedge clk);
    model_edge(0, a_rst, a_start, a_halt);
    model_edge(1, b_rst, b_start, b_halt);
    #1;
  endtask

  task automatic test_reset;
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (10) tick();
    n_checks++; if (obs_a() !== 21'h100000) $display("FAIL reset_a: got %h expected %h", obs_a(), 21'h100000); else n_pass++;
    n_checks++; if (obs_b() !== 21'h100000) $display("FAIL reset_b: got %h expected %h", obs_b(), 21'h100000); else n_pass++;
    a_rst = 1'b0; b_rst = 1'b0;
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    while (a_cpu_rst === 1'b1 && n < 50) begin
      n++; tick();
      n_checks++; if (obs_a() !== exp_vec(0)) $display("FAIL timeout_hold_model: got %h expected %h", obs_a(), exp_vec(0)); else n_pass++;
    end
    n_checks++; if (n !== 10) $display("FAIL hold_len: got %0d expected 10", n); else n_pass++;
    n = 0;
    while (a_running === 1'b1 && n < 300) begin
      n++; tick();
      n_checks++; if (obs_a() !== exp_vec(0)) $display("FAIL timeout_run_model: got %h expected %h", obs_a(), exp_vec(0)); else n_pass++;
    end
    n_checks++; if (n !== 100) $display("FAIL run_len: got %0d expected 100", n); else n_pass++;
    n_checks++;
    if ({a_done, a_timeout, a_stall, a_cpu_rst, a_cycles} !== {4'b1110, 16'd100})
      $display("FAIL timeout_status: got %b %b %b %b %0d expected 1 1 1 0 100", a_done, a_timeout, a_stall, a_cpu_rst, a_cycles);
    else n_pass++;
  endtask

  task automatic restart_to_run;
    int n;
    a_start = 1'b1; tick(); a_start = 1'b0;
    n = 0;
    while (a_running !== 1'b1 && n < 50) begin tick(); n++; end
  endtask

  task automatic test_halt;
    restart_to_run();
    n_checks++; if ({a_running, a_cycles} !== {1'b1, 16'd0}) $display("FAIL halt_enter_run: got %b %0d expected 1 0", a_running, a_cycles); else n_pass++;
    repeat (36) tick();
    a_halt = 1'b1; tick(); a_halt = 1'b0;
    n_checks++;
    if ({a_done, a_timeout, a_cycles} !== {2'b10, 16'd37})
      $display("FAIL halt_37: got %b %b %0d expected 1 0 37", a_done, a_timeout, a_cycles);
    else n_pass++;
    repeat (50) begin
      a_halt = 1'($urandom_range(0, 1));
      tick();
      n_checks++; if (obs_a() !== exp_vec(0)) $display("FAIL halt_hold_model: got %h expected %h", obs_a(), exp_vec(0)); else n_pass++;
    end
    a_halt = 1'b0;
    n_checks++; if (a_cycles !== 16'd37) $display("FAIL halt_hold: got %0d expected 37", a_cycles); else n_pass++;
  endtask

  task automatic test_halt_at_budget;
    restart_to_run();
    repeat (99) tick();
    n_checks++; if ({a_running, a_cycles} !== {1'b1, 16'd99}) $display("FAIL budget_pre: got %b %0d expected 1 99", a_running, a_cycles); else n_pass++;
    a_halt = 1'b1; tick(); a_halt = 1'b0;
    n_checks++;
    if ({a_done, a_timeout, a_cycles} !== {2'b10, 16'd100})
      $display("FAIL halt_priority: got %b %b %0d expected 1 0 100", a_done, a_timeout, a_cycles);
    else n_pass++;
  endtask

  task automatic test_restart;
    int n;
    a_start = 1'b1; tick(); a_start = 1'b0;
    n_checks++;
    if ({a_cpu_rst, a_done, a_timeout, a_cycles} !== {3'b100, 16'd0})
      $display("FAIL restart_clear: got %b %b %b %0d expected 1 0 0 0", a_cpu_rst, a_done, a_timeout, a_cycles);
    else n_pass++;
    n = 0;
    while (a_cpu_rst === 1'b1 && n < 50) begin n++; tick(); end
    n_checks++; if (n !== 10) $display("FAIL restart_hold_len: got %0d expected 10", n); else n_pass++;
    repeat (5) tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    n_checks++;
    if ({a_running, a_cpu_rst, a_cycles} !== {2'b10, 16'd6})
      $display("FAIL start_in_run: got %b %b %0d expected 1 0 6", a_running, a_cpu_rst, a_cycles);
    else n_pass++;
  endtask

  task automatic test_rst_midrun;
    int n;
    n = 0;
    while (a_cycles !== 16'd49 && n < 200) begin tick(); n++; end
    a_rst = 1'b1; a_halt = 1'b1; tick(); a_rst = 1'b0; a_halt = 1'b0;
    n_checks++;
    if ({a_cpu_rst, a_running, a_done, a_cycles} !== {3'b100, 16'd0})
      $display("FAIL rst_midrun: got %b %b %b %0d expected 1 0 0 0", a_cpu_rst, a_running, a_done, a_cycles);
    else n_pass++;
    n = 0;
    while (a_cpu_rst === 1'b1 && n < 50) begin n++; tick(); end
    n_checks++; if (n !== 10) $display("FAIL rst_midrun_hold: got %0d expected 10", n); else n_pass++;
  endtask

  task automatic test_small;
    b_rst = 1'b1; tick(); b_rst = 1'b0;
    n_checks++; if (b_cpu_rst !== 1'b1) $display("FAIL small_hold: got %b expected 1", b_cpu_rst); else n_pass++;
    tick();
    n_checks++; if ({b_cpu_rst, b_running} !== 2'b01) $display("FAIL small_run: got %b expected 01", {b_cpu_rst, b_running}); else n_pass++;
    repeat (40) begin
      tick();
      n_checks++; if (obs_b() !== exp_vec(1)) $display("FAIL small_model: got %h expected %h", obs_b(), exp_vec(1)); else n_pass++;
    end
    n_checks++; if ({b_done, b_cycles} !== {1'b0, 4'd15}) $display("FAIL small_saturate: got %b %0d expected 0 15", b_done, b_cycles); else n_pass++;
    b_halt = 1'b1; tick(); b_halt = 1'b0;
    n_checks++;
    if ({b_done, b_timeout, b_cycles} !== {2'b10, 4'd15})
      $display("FAIL small_halt: got %b %b %0d expected 1 0 15", b_done, b_timeout, b_cycles);
    else n_pass++;
  endtask

  task automatic test_random;
    repeat (600) begin
      a_rst   = ($urandom_range(0, 59) == 0);
      a_start = ($urandom_range(0, 7) == 0);
      a_halt  = ($urandom_range(0, 39) == 0);
      b_rst   = ($urandom_range(0, 59) == 0);
      b_start = ($urandom_range(0, 7) == 0);
      b_halt  = ($urandom_range(0, 29) == 0);
      tick();
      n_checks++; if (obs_a() !== exp_vec(0)) $display("FAIL random_a: got %h expected %h", obs_a(), exp_vec(0)); else n_pass++;
      n_checks++; if (obs_b() !== exp_vec(1)) $display("FAIL random_b: got %h expected %h", obs_b(), exp_vec(1)); else n_pass++;
    end
    a_rst = 1'b0; a_start = 1'b0; a_halt = 1'b0;
    b_rst = 1'b0; b_start = 1'b0; b_halt = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_timeout();
    test_halt();
    test_halt_at_budget();
    test_restart();
    test_rst_midrun();
    test_small();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/openmips_run_ctrl.md
Name: openmips_run_ctrl

Overview:
Synthesizable run controller for the OpenMIPS minimal SOPC. It generates the CPU reset pulse, enforces a run-cycle budget, and detects program completion, replacing the simulation-only reset and stop sequencing on the board.
It sits between the board reset and clock and the openmips_min_sopc instance. It drives the SOPC's reset and stall, and reports done or timeout status to LEDs or a debug bus.

Parameters:
HOLD_CYCLES, 10, cycles the CPU reset is held after rst deasserts (values below 1 behave as 1)
RUN_CYCLES, 100, run budget in cycles before forced stop; 0 = no budget
CNT_W, 16, width of the cycle counters

Ports:
clk  input  1  system clock (50 MHz on board)
rst  input  1  reset; synchronous, active-high (RstEnable = 1'b1)
start_i  input  1  rerun request; honoured only in DONE
halt_i  input  1  CPU reports program end (e.g. halt-register write); sampled in RUN only
cpu_rst_o  output  1  reset to openmips_min_sopc, active-high
cpu_stall_o  output  1  freezes CPU pipeline while high
running_o  output  1  high in RUN
done_o  output  1  high in DONE
timeout_o  output  1  high in DONE when the stop was caused by the budget
cycles_o  output  CNT_W  number of RUN cycles executed in the current or last run

Behaviour:
- States: HOLD, RUN, DONE. Registered Moore outputs, except that cycles_o is the counter itself.
- rst=1 at a clock edge forces the following values, also mid-run:
  - state=HOLD, hold_cnt=0, cycles_o=0
  - cpu_rst_o=1, cpu_stall_o=0, running_o=0, done_o=0, timeout_o=0
- HOLD:
  - cpu_rst_o=1; hold_cnt increments each cycle.
  - When hold_cnt==max(HOLD_CYCLES,1)-1, go to RUN at the next edge.
  - Result: exactly max(HOLD_CYCLES,1) cycles of cpu_rst_o=1 after the first edge with rst=0.
- RUN:
  - cpu_rst_o=0, running_o=1; cycles_o increments every RUN cycle, including the exit cycle.
  - halt_i=1: go to DONE with timeout_o=0.
  - Else, if RUN_CYCLES!=0 and cycles_o==RUN_CYCLES-1 (pre-increment): go to DONE with timeout_o=1.
  - If halt_i and the budget expire in the same cycle, halt wins: timeout_o=0.
  - With RUN_CYCLES=0, cycles_o saturates at all-ones and never wraps; the controller stays in RUN until halt_i.
- DONE:
  - cpu_stall_o=1, cpu_rst_o=0, done_o=1; cycles_o and timeout_o hold.
  - start_i=1: go to HOLD, clear hold_cnt, cycles_o and timeout_o.
  - start_i in HOLD or RUN is ignored. halt_i outside RUN is ignored.
- Transitions take effect at the edge after the triggering cycle. Outputs reflect the new state in the cycle after that edge (one-cycle latency from halt_i to done_o).
- rst=1 overrides start_i and halt_i in the same cycle.
- No combinational path from any input to any output.

Test Plan:
1. rst=1 for 10 cycles, then 0, defaults, halt_i=0:
   - cpu_rst_o stays 1 for exactly 10 cycles after rst falls.
   - running_o=1 for 100 cycles.
   - Then done_o=1, timeout_o=1, cycles_o=100, cpu_stall_o=1.
2. halt_i pulsed on the 37th RUN cycle:
   - Next cycle done_o=1, timeout_o=0, cycles_o=37.
   - cycles_o stays 37 for 50 further cycles.
3. halt_i asserted on the 100th RUN cycle (RUN_CYCLES=100): done_o=1, timeout_o=0, cycles_o=100 (halt priority).
4. In DONE, pulse start_i for one cycle:
   - cycles_o=0, timeout_o=0, cpu_rst_o=1 for 10 cycles, then RUN again.
   - start_i pulsed during RUN has no effect.
5. rst asserted on the 50th RUN cycle for 1 cycle: next cycle cpu_rst_o=1, cycles_o=0, running_o=0, then a 10-cycle hold.
6. HOLD_CYCLES=0, RUN_CYCLES=0, CNT_W=4, no halt:
   - cpu_rst_o=1 for 1 cycle.
   - cycles_o reaches 15 and stays 15; done_o stays 0.
   - A later halt_i gives done_o=1, timeout_o=0.
